// File: rtl/cia_bus_sequencer.sv
// rtl/cia_bus_sequencer.sv - Round-robin sequencer granting two requesters whole E periods on a pair of CIAs.
// E is a free-running divide-by-10 phase clock; each access occupies one full E period.
module cia_bus_sequencer (
  input  logic       CLK,
  input  logic       RES,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       WE0,
  input  logic       WE1,
  input  logic [4:0] ADDR0,
  input  logic [4:0] ADDR1,
  input  logic [7:0] WDATA0,
  input  logic [7:0] WDATA1,
  output logic       ACK0,
  output logic       ACK1,
  output logic [7:0] RDATA,
  output logic       E,
  output logic       _CS_A,
  output logic       _CS_B,
  output logic       R_W,
  output logic [3:0] RS,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  input  logic [7:0] D_IN
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_ph;
  logic [3:0] w_ph_next;
  logic       w_ph_end;
  logic       r_e;
  logic       r_last;
  logic       r_sel;
  logic       r_we;
  logic [4:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic       r_ack0;
  logic       r_ack1;
  logic       w_access;
  logic       w_elig0;
  logic       w_elig1;
  logic       w_grant;
  logic       w_win;

  assign w_access  = (r_state == S_ACCESS);
  assign w_ph_end  = (r_ph == 4'd9);
  assign w_ph_next = w_ph_end ? 4'd0 : r_ph + 4'd1;

  // The requester currently on the bus is masked so only the other side can be re-granted back-to-back.
  assign w_elig0 = REQ0 & ~(w_access & ~r_sel);
  assign w_elig1 = REQ1 & ~(w_access & r_sel);
  assign w_grant = w_ph_end & (w_elig0 | w_elig1);
  assign w_win   = (w_elig0 & w_elig1) ? ~r_last : w_elig1;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_ph_end) begin
      w_state_next = w_grant ? S_ACCESS : S_IDLE;
    end
  end

  always_comb begin
    _CS_A = ~(w_access & ~r_addr[4]);
    _CS_B = ~(w_access & r_addr[4]);
    R_W   = ~(w_access & r_we);
    D_OE  = w_access & r_we;
    RS    = r_addr[3:0];
    D_OUT = r_wdata;
    ACK0  = r_ack0;
    ACK1  = r_ack1;
    RDATA = r_rdata;
    E     = r_e;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_ph    <= 4'd0;
      r_e     <= 1'b0;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 5'd0;
      r_wdata <= 8'd0;
      r_rdata <= 8'd0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_ph   <= w_ph_next;
      r_e    <= (w_ph_next >= 4'd6);
      r_ack0 <= w_ph_end & w_access & ~r_sel;
      r_ack1 <= w_ph_end & w_access & r_sel;
      if (w_ph_end && w_access && !r_we) begin
        r_rdata <= D_IN;
      end
      if (w_grant) begin
        r_last  <= w_win;
        r_sel   <= w_win;
        r_we    <= w_win ? WE1 : WE0;
        r_addr  <= w_win ? ADDR1 : ADDR0;
        r_wdata <= w_win ? WDATA1 : WDATA0;
      end
    end
  end

endmodule

// File: tb/tb_cia_bus_sequencer.sv
// tb/tb_cia_bus_sequencer.sv - Directed and randomized bench for cia_bus_sequencer against a transaction-level model.
module tb_cia_bus_sequencer;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       REQ0, REQ1, WE0, WE1;
  logic [4:0] ADDR0, ADDR1;
  logic [7:0] WDATA0, WDATA1;
  logic       ACK0, ACK1;
  logic [7:0] RDATA;
  logic       E;
  logic       _CS_A, _CS_B, R_W;
  logic [3:0] RS;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic [7:0] D_IN = 8'h00;

  logic       rq [2];
  logic       rwe [2];
  logic [4:0] raddr [2];
  logic [7:0] rwd [2];
  int         t0 [2];
  logic [1:0] w_ack;

  assign REQ0 = rq[0];   assign REQ1 = rq[1];
  assign WE0 = rwe[0];   assign WE1 = rwe[1];
  assign ADDR0 = raddr[0]; assign ADDR1 = raddr[1];
  assign WDATA0 = rwd[0];  assign WDATA1 = rwd[1];
  assign w_ack = {ACK1, ACK0};

  cia_bus_sequencer dut (
    .CLK(CLK), .RES(RES),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .E(E),
    ._CS_A(_CS_A), ._CS_B(_CS_B), .R_W(R_W), .RS(RS),
    .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transaction model: cycles since reset give the phase; a grant is a whole-period bus tenure.
  int         m_t;
  logic       m_act, m_who, m_we, m_last, m_ack0, m_ack1, m_e0, m_e1;
  logic [4:0] m_addr;
  logic [7:0] m_wd, m_rdata;

  always @(posedge CLK) cyc++;

  always @(posedge CLK or posedge RES) begin
    if (RES) begin
      m_t = 0; m_act = 0; m_who = 0; m_we = 0; m_last = 1;
      m_addr = 0; m_wd = 0; m_rdata = 0; m_ack0 = 0; m_ack1 = 0;
    end else begin
      m_ack0 = 0; m_ack1 = 0;
      if (m_t % 10 == 9) begin
        if (m_act) begin
          if (m_who == 0) m_ack0 = 1; else m_ack1 = 1;
          if (!m_we) m_rdata = D_IN;
        end
        m_e0 = REQ0 && !(m_act && m_who == 0);
        m_e1 = REQ1 && !(m_act && m_who == 1);
        if (m_e0 && m_e1) m_who = !m_last;
        else if (m_e0) m_who = 0;
        else if (m_e1) m_who = 1;
        m_act = m_e0 || m_e1;
        if (m_act) begin
          m_last = m_who;
          m_we   = m_who ? WE1 : WE0;
          m_addr = m_who ? ADDR1 : ADDR0;
          m_wd   = m_who ? WDATA1 : WDATA0;
        end
      end
      m_t++;
    end
  end

  always @(posedge CLK) begin
    #1;
    chk("E", E, (m_t % 10) >= 6);
    chk("CS_A", _CS_A, !(m_act && !m_addr[4]));
    chk("CS_B", _CS_B, !(m_act && m_addr[4]));
    chk("R_W", R_W, !(m_act && m_we));
    chk("D_OE", D_OE, m_act && m_we);
    chk("RS", RS, m_addr[3:0]);
    chk("D_OUT", D_OUT, m_wd);
    chk("ACK", w_ack, {m_ack1, m_ack0});
    chk("RDATA", RDATA, m_rdata);
    chk("one_cs", !_CS_A && !_CS_B, 0);
  end

  task automatic check_reset_vals(input string nm);
    chk(nm, {_CS_A, _CS_B, R_W, D_OE, RS, D_OUT, ACK0, ACK1, RDATA, E},
        {1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
  endtask

  int k;
  int ack_who [4];
  int ack_cyc [4];
  int nack;
  logic bad;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; rwe[i] = 0; raddr[i] = 0; rwd[i] = 0; t0[i] = 0;
    end
    repeat (3) @(negedge CLK);
    check_reset_vals("reset_state");
    RES = 0;

    // Free-running E: PH=k after k edges, high for PH 6..9.
    for (int j = 1; j <= 20; j++) begin
      @(negedge CLK);
      chk("e_pattern", E, (j % 10) >= 6);
    end

    // Read from CIA B register 0xD.
    D_IN = 8'h5A; rq[0] = 1; rwe[0] = 0; raddr[0] = 5'h1D; rwd[0] = 8'h00;
    k = 0;
    while (_CS_B !== 1'b0 && k < 25) begin @(negedge CLK); k++; end
    chk("read_grant", _CS_B, 0);
    for (int j = 0; j < 10; j++) begin
      chk("read_bus", {_CS_A, _CS_B, R_W, D_OE, RS}, {1'b1, 1'b0, 1'b1, 1'b0, 4'hD});
      @(negedge CLK);
    end
    chk("read_ack0", {ACK1, ACK0}, 2'b01);
    chk("read_rdata", RDATA, 8'h5A);
    rq[0] = 0;
    D_IN = 8'hEE;

    // Write to CIA A register 3.
    @(negedge CLK);
    rq[1] = 1; rwe[1] = 1; raddr[1] = 5'h03; rwd[1] = 8'hC3;
    k = 0;
    while (_CS_A !== 1'b0 && k < 25) begin @(negedge CLK); k++; end
    chk("write_grant", _CS_A, 0);
    for (int j = 0; j < 10; j++) begin
      chk("write_bus", {_CS_A, _CS_B, R_W, D_OE, RS, D_OUT}, {1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 8'hC3});
      @(negedge CLK);
    end
    chk("write_ack1", {ACK1, ACK0}, 2'b10);
    chk("write_rdata_kept", RDATA, 8'h5A);
    rq[1] = 0;

    // Contention: both held, last grant was requester 1.
    @(negedge CLK);
    rq[0] = 1; rwe[0] = 0; raddr[0] = 5'h02;
    rq[1] = 1; rwe[1] = 0; raddr[1] = 5'h14;
    nack = 0; k = 0;
    while (nack < 4 && k < 60) begin
      @(negedge CLK); k++;
      if (ACK0 || ACK1) begin
        ack_who[nack] = ACK1 ? 1 : 0;
        ack_cyc[nack] = cyc;
        nack++;
      end
    end
    chk("cont_count", nack, 4);
    for (int j = 0; j < 4; j++) chk("cont_order", ack_who[j], j % 2);
    for (int j = 1; j < 4; j++) chk("cont_spacing", ack_cyc[j] - ack_cyc[j-1], 10);
    rq[0] = 0; rq[1] = 0;
    repeat (15) @(negedge CLK);

    // Cancel: REQ0 high during PH 1..3 only.
    k = 0;
    while (m_t % 10 != 1 && k < 12) begin @(negedge CLK); k++; end
    rq[0] = 1; rwe[0] = 1; raddr[0] = 5'h07;
    repeat (3) @(negedge CLK);
    rq[0] = 0;
    bad = 0;
    for (int j = 0; j < 25; j++) begin
      if (!_CS_A || !_CS_B || ACK0) bad = 1;
      @(negedge CLK);
    end
    chk("cancel_quiet", bad, 0);

    // Reset at PH=4 of an access.
    rq[0] = 1; rwe[0] = 0; raddr[0] = 5'h05; D_IN = 8'h99;
    k = 0;
    while (_CS_A !== 1'b0 && k < 25) begin @(negedge CLK); k++; end
    chk("rst_grant", _CS_A, 0);
    repeat (4) @(negedge CLK);
    RES = 1; rq[0] = 0;
    #1;
    check_reset_vals("rst_immediate");
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge CLK);
      if (ACK0 || ACK1) bad = 1;
      if (j == 2) RES = 0;
    end
    chk("rst_no_ack", bad, 0);
    D_IN = 8'h3C; rq[0] = 1;
    k = 0;
    while (ACK0 !== 1'b1 && k < 22) begin @(negedge CLK); k++; end
    chk("rst_reacc_ack", ACK0, 1);
    chk("rst_reacc_rdata", RDATA, 8'h3C);
    rq[0] = 0;
    @(negedge CLK);

    // Randomized traffic; requesters hold until ACK, then maybe re-request at once.
    for (int n = 0; n < 1500; n++) begin
      @(negedge CLK);
      D_IN = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (rq[i] && w_ack[i]) begin
          chk("latency", (cyc - t0[i]) <= 30, 1);
          if ($urandom_range(0, 1) == 1) begin
            rwe[i] = 1'($urandom); raddr[i] = 5'($urandom); rwd[i] = 8'($urandom);
            t0[i] = cyc;
          end else begin
            rq[i] = 0;
          end
        end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
          rq[i] = 1;
          rwe[i] = 1'($urandom); raddr[i] = 5'($urandom); rwd[i] = 8'($urandom);
          t0[i] = cyc;
        end else if (rq[i] && (cyc - t0[i]) > 31) begin
          chk("latency_timeout", cyc - t0[i], 30);
          rq[i] = 0;
        end
      end
    end
    rq[0] = 0; rq[1] = 0;
    repeat (25) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cia_bus_sequencer.md
CIA_BUS_SEQUENCER -- requirements
Module: cia_bus_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1: system clock; all state changes on its rising edge.
REQ-002 SHALL have port RES, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have ports REQ0/REQ1, input, 1 each: requester n asks for one CIA register access.
REQ-004 SHALL have ports WE0/WE1, input, 1 each: 1 = write, 0 = read.
REQ-005 SHALL have ports ADDR0/ADDR1, input, 5 each: bit4 selects the CIA (0 = A, 1 = B); bits[3:0] give the register select.
REQ-006 SHALL have ports WDATA0/WDATA1, input, 8 each: write data.
REQ-007 SHALL have ports ACK0/ACK1, output, 1 each: one-cycle completion pulse.
REQ-008 SHALL have port RDATA, output, 8: read data, shared by both requesters.
REQ-009 SHALL have port E, output, 1: CIA phase-2 clock, driven to CLK_2 of both CIAs.
REQ-010 SHALL have ports _CS_A/_CS_B, output, 1 each: active-low chip selects.
REQ-011 SHALL have port R_W, output, 1: 1 = read, 0 = write.
REQ-012 SHALL have port RS, output, 4: CIA register select.
REQ-013 SHALL have ports D_OUT (output, 8), D_OE (output, 1) and D_IN (input, 8): CIA data bus halves.

Function
REQ-014 SHALL contain a mod-10 phase counter PH (0..9) that increments every CLK and wraps 9->0.
REQ-015 SHALL register E so that E=1 while PH is 6..9 and E=0 while PH is 0..5 (6 cycles low, 4 high).
REQ-016 SHALL implement two states: IDLE and ACCESS.
REQ-017 SHALL evaluate requests only at the PH=9 edge; the granted access occupies the whole next E period (PH 0..9).
REQ-018 Arbitration SHALL be round-robin:
  - single request: that requester wins;
  - both requesting: the requester not granted last wins;
  - after reset, "last" = 1, so REQ0 wins the first tie.
REQ-019 On grant, SHALL latch the winner's WE, ADDR and WDATA, then go to ACCESS.
REQ-020 During ACCESS (PH 0..9), SHALL drive:
  - the selected _CS_x = 0 and the other _CS = 1;
  - R_W = ~WE and RS = ADDR[3:0];
  - D_OUT = WDATA, with D_OE = 1 for writes and 0 for reads.
REQ-021 At the PH=9 edge of ACCESS, SHALL:
  - for reads, latch D_IN into RDATA;
  - pulse the granted ACKn high for exactly one cycle (the PH=0 cycle that follows);
  - release _CS and D_OE;
  - return to IDLE, or re-grant immediately if a request is pending.
REQ-022 RDATA SHALL hold its value until the next read completes; writes SHALL leave RDATA unchanged.
REQ-023 In IDLE, SHALL drive _CS_A = _CS_B = 1, R_W = 1, D_OE = 0; RS and D_OUT hold their last values.
REQ-024 Requester protocol:
  - REQn, WEn, ADDRn and WDATAn are held stable until ACKn;
  - REQn deasserted before grant cancels the request with no bus activity;
  - REQn is ignored from grant until ACKn;
  - REQn still high in the ACKn cycle is a new request.
REQ-025 Worst-case latency SHALL be: request to ACK ≤ 30 cycles with contention, ≤ 20 cycles without.
REQ-026 SHALL assert at most one ACK per cycle and never assert _CS_A and _CS_B together.

Reset
REQ-027 While RES=1, SHALL force:
  - PH=0, E=0, state IDLE, last-grant=1;
  - _CS_A=_CS_B=1, R_W=1, RS=0, D_OUT=0, D_OE=0;
  - ACK0=ACK1=0, RDATA=0x00.
REQ-028 Reset during ACCESS SHALL abort the access with no ACK; the requester must re-request.
REQ-029 After RES falls, PH SHALL count from 0 on the first CLK edge.

Verification
REQ-030 Free-running E: after reset release, E is low for 6 cycles and high for 4, repeating with period 10.
REQ-031 Read: REQ0=1, WE0=0, ADDR0=0x1D, D_IN=0x5A:
  - _CS_B=0, R_W=1, RS=0xD for 10 cycles;
  - ACK0 pulse, RDATA=0x5A.
REQ-032 Write: REQ1=1, WE1=1, ADDR1=0x03, WDATA1=0xC3:
  - _CS_A=0, R_W=0, D_OE=1, D_OUT=0xC3 for 10 cycles;
  - ACK1 pulse;
  - RDATA unchanged.
REQ-033 Contention: REQ0 and REQ1 raised together and held:
  - grants alternate 0,1,0,1;
  - ACKs spaced 10 cycles apart;
  - no cycle has both _CS low.
REQ-034 Cancel: REQ0 pulsed high 3 cycles, all before PH=9 -> no _CS activity, no ACK0.
REQ-035 Reset mid-access: RES=1 at PH=4 of ACCESS:
  - all outputs return to reset values immediately;
  - no ACK;
  - a new request after release completes normally.
